fsmoniter_core: RTL and testbench

- Frame-sync measurement engine that feeds the Fsmoniter AXI4-Lite register slave.
- Samples an asynchronous frame-sync strobe and measures its period in ACLK cycles, its high-pulse width, and the frame count.
- Detects lock and timeout conditions.
- All outputs are registered and read directly by the 4-word register file (0x0 period, 0x4 high width, 0x8 frame count, 0xC status).

---
 rtl/fsmoniter_pkg.sv | 30 +++
 rtl/fsmoniter_sync.sv | 31 +++
 rtl/fsmoniter_core.sv | 218 +++++++++++++++++++++
 tb/tb_fsmoniter_core.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fsmoniter_pkg.sv
// Shared types and constants for the frame-sync monitor: FSM states, default
// counter width and the status-word bit layout used by the register file.
package fsmoniter_pkg;

    localparam int DEFAULT_CNT_W = 32;

    localparam int STATUS_LOCKED_BIT  = 0;
    localparam int STATUS_TIMEOUT_BIT = 1;
    localparam int STATUS_ENABLE_BIT  = 2;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FIRST = 2'd1,
        MEASURE    = 2'd2,
        TIMEOUT    = 2'd3
    } fsm_state_t;

    // Assembles the 0xC status word from the individual flags.
    function automatic logic [31:0] packStatus(input logic locked,
                                               input logic timeout,
                                               input logic enable);
        logic [31:0] status;
        status                     = '0;
        status[STATUS_LOCKED_BIT]  = locked;
        status[STATUS_TIMEOUT_BIT] = timeout;
        status[STATUS_ENABLE_BIT]  = enable;
        return status;
    endfunction

endpackage

// File: rtl/fsmoniter_sync.sv
// Brings the asynchronous frame-sync strobe into the ACLK domain and derives
// single-cycle rise/fall strobes from the synchronized level.
module fsmoniter_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic ACLK,
    input  logic ARESETN,
    input  logic fs_in,
    output logic fs_s,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], fs_in};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign fs_s = r_sync[SYNC_STAGES-1];
    assign rise = r_sync[SYNC_STAGES-1] & ~r_prev;
    assign fall = ~r_sync[SYNC_STAGES-1] & r_prev;

endmodule

// File: rtl/fsmoniter_core.sv
// Frame-sync measurement engine: period, high width, frame count, lock and
// timeout detection, all registered for direct readout by the register file.
module fsmoniter_core
    import fsmoniter_pkg::*;
#(
    parameter int CNT_W       = DEFAULT_CNT_W,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_FRAMES = 3,
    parameter int LOCK_TOL    = 2
) (
    input  logic             ACLK,
    input  logic             ARESETN,
    input  logic             fs_in,
    input  logic             enable,
    input  logic             clear,
    input  logic [CNT_W-1:0] timeout_cycles,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_width,
    output logic [CNT_W-1:0] frame_cnt,
    output logic             period_valid,
    output logic             locked,
    output logic             timeout
);

    localparam int                LCW      = $clog2(LOCK_FRAMES + 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  TOL      = CNT_W'(LOCK_TOL);
    localparam logic [LCW-1:0]    LOCK_MAX = LCW'(LOCK_FRAMES);
    localparam logic [LCW-1:0]    LCW_ONE  = LCW'(1);

    fsm_state_t       r_state;
    fsm_state_t       w_nextState;

    logic             w_fs;
    logic             w_rise;
    logic             w_fall;
    logic             w_accept;
    logic             w_latch;
    logic             w_fire;
    logic             w_toHit;
    logic             w_inTol;
    logic [CNT_W-1:0] w_diff;

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_wcnt;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_highWidth;
    logic [CNT_W-1:0] r_frameCnt;
    logic [CNT_W-1:0] r_prevPeriod;
    logic [LCW-1:0]   r_lockCnt;
    logic             r_havePrev;
    logic             r_armed;
    logic             r_periodValid;
    logic             r_locked;
    logic             r_timeout;

    fsmoniter_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .ACLK    (ACLK),
        .ARESETN (ARESETN),
        .fs_in   (fs_in),
        .fs_s    (w_fs),
        .rise    (w_rise),
        .fall    (w_fall)
    );

    assign w_toHit = (timeout_cycles != '0) && (r_cnt == timeout_cycles);
    assign w_diff  = (r_cnt >= r_prevPeriod) ? (r_cnt - r_prevPeriod)
                                             : (r_prevPeriod - r_cnt);
    assign w_inTol = (w_diff <= TOL);

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // clear beats everything (including a coincident edge); enable low parks in IDLE.
    always_comb begin
        w_nextState = r_state;
        w_accept    = 1'b0;
        w_latch     = 1'b0;
        w_fire      = 1'b0;
        if (clear) begin
            w_nextState = enable ? WAIT_FIRST : IDLE;
        end else if (!enable) begin
            w_nextState = IDLE;
        end else begin
            unique case (r_state)
                IDLE: begin
                    w_nextState = WAIT_FIRST;
                end
                WAIT_FIRST: begin
                    if (w_rise) begin
                        w_accept    = 1'b1;
                        w_nextState = MEASURE;
                    end
                end
                MEASURE: begin
                    if (w_rise) begin
                        w_accept = 1'b1;
                        w_latch  = 1'b1;
                    end else if (w_toHit) begin
                        w_fire      = 1'b1;
                        w_nextState = TIMEOUT;
                    end
                end
                TIMEOUT: begin
                    if (w_rise) begin
                        w_accept    = 1'b1;
                        w_nextState = MEASURE;
                    end
                end
                default: begin
                    w_nextState = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_cnt         <= '0;
            r_wcnt        <= '0;
            r_period      <= '0;
            r_highWidth   <= '0;
            r_frameCnt    <= '0;
            r_prevPeriod  <= '0;
            r_lockCnt     <= '0;
            r_havePrev    <= 1'b0;
            r_armed       <= 1'b0;
            r_periodValid <= 1'b0;
            r_locked      <= 1'b0;
            r_timeout     <= 1'b0;
        end else begin
            r_periodValid <= w_latch;
            if (clear) begin
                r_cnt        <= '0;
                r_wcnt       <= '0;
                r_period     <= '0;
                r_highWidth  <= '0;
                r_frameCnt   <= '0;
                r_prevPeriod <= '0;
                r_lockCnt    <= '0;
                r_havePrev   <= 1'b0;
                r_armed      <= 1'b0;
                r_locked     <= 1'b0;
                r_timeout    <= 1'b0;
            end else if (!enable || r_state == IDLE) begin
                r_cnt   <= '0;
                r_wcnt  <= '0;
                r_armed <= 1'b0;
            end else begin
                // The interval counter only runs in MEASURE and freezes once a timeout fires.
                if (w_accept) begin
                    r_cnt <= CNT_ONE;
                end else if (r_state == MEASURE && !w_fire && r_cnt != CNT_MAX) begin
                    r_cnt <= r_cnt + CNT_ONE;
                end

                if (w_accept && r_frameCnt != CNT_MAX) begin
                    r_frameCnt <= r_frameCnt + CNT_ONE;
                end

                if (w_latch) begin
                    r_period     <= r_cnt;
                    r_prevPeriod <= r_cnt;
                    r_havePrev   <= 1'b1;
                    if (r_havePrev) begin
                        if (w_inTol) begin
                            if (r_lockCnt < LOCK_MAX) begin
                                r_lockCnt <= r_lockCnt + LCW_ONE;
                            end
                            if (r_lockCnt >= LOCK_MAX - LCW_ONE) begin
                                r_locked <= 1'b1;
                            end
                        end else begin
                            r_lockCnt <= '0;
                            r_locked  <= 1'b0;
                        end
                    end
                end else if (w_accept) begin
                    r_havePrev <= 1'b0;
                end

                if (w_fire) begin
                    r_timeout <= 1'b1;
                    r_locked  <= 1'b0;
                    r_lockCnt <= '0;
                end

                // A fall only reports a width once a rise has been seen since enable/clear.
                if (w_rise) begin
                    r_wcnt  <= CNT_ONE;
                    r_armed <= 1'b1;
                end else if (w_fs && r_wcnt != CNT_MAX) begin
                    r_wcnt <= r_wcnt + CNT_ONE;
                end

                if (w_fall && r_armed) begin
                    r_highWidth <= r_wcnt;
                end
            end
        end
    end

    assign period       = r_period;
    assign high_width   = r_highWidth;
    assign frame_cnt    = r_frameCnt;
    assign period_valid = r_periodValid;
    assign locked       = r_locked;
    assign timeout      = r_timeout;

endmodule

// File: tb/tb_fsmoniter_core.sv
// Randomized self-checking bench for fsmoniter_core; a pulse-level model
// predicts every period_valid record from the driven fs_in waveform.
module tb_fsmoniter_core;

    localparam int LOCK_FRAMES = 3;
    localparam int LOCK_TOL    = 2;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic        fs_in;
    logic        enable;
    logic        clear;
    logic [31:0] timeout_cycles;
    logic [31:0] period;
    logic [31:0] high_width;
    logic [31:0] frame_cnt;
    logic        period_valid;
    logic        locked;
    logic        timeout;

    logic        fs8;
    logic        en8;
    logic        clr8;
    logic [7:0]  to8;
    logic [7:0]  period8;
    logic [7:0]  hw8;
    logic [7:0]  frame8;
    logic        pv8;
    logic        lk8;
    logic        tmo8;

    fsmoniter_core #(
        .CNT_W(32), .SYNC_STAGES(2), .LOCK_FRAMES(LOCK_FRAMES), .LOCK_TOL(LOCK_TOL)
    ) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .fs_in(fs_in), .enable(enable),
        .clear(clear), .timeout_cycles(timeout_cycles), .period(period),
        .high_width(high_width), .frame_cnt(frame_cnt),
        .period_valid(period_valid), .locked(locked), .timeout(timeout)
    );

    fsmoniter_core #(
        .CNT_W(8), .SYNC_STAGES(2), .LOCK_FRAMES(LOCK_FRAMES), .LOCK_TOL(LOCK_TOL)
    ) dut8 (
        .ACLK(ACLK), .ARESETN(ARESETN), .fs_in(fs8), .enable(en8),
        .clear(clr8), .timeout_cycles(to8), .period(period8),
        .high_width(hw8), .frame_cnt(frame8),
        .period_valid(pv8), .locked(lk8), .timeout(tmo8)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        logic [31:0] period;
        logic [31:0] hw;
        logic [31:0] frame;
        logic        locked;
    } rec_t;

    rec_t        capQ[$];
    rec_t        expQ[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          lastFrameCyc = 0;
    int          toRiseCyc = -1;
    logic [31:0] prevFrame = '0;
    logic        prevTo = 1'b0;

    int mFrames, mPrev, mStreak, mGap, mH;
    bit mSeen, mHavePrev, mLocked;

    // One clock; outputs are sampled 1 ns after the edge and period_valid records are captured.
    task automatic step();
        @(posedge ACLK);
        #1;
        cyc++;
        if (period_valid === 1'b1) capQ.push_back('{period, high_width, frame_cnt, locked});
        if (frame_cnt !== prevFrame) lastFrameCyc = cyc;
        if (timeout === 1'b1 && prevTo === 1'b0) toRiseCyc = cyc;
        prevFrame = frame_cnt;
        prevTo    = timeout;
    endtask

    task automatic modelClear();
        mFrames = 0; mStreak = 0; mLocked = 0;
        mSeen = 0; mHavePrev = 0; mPrev = 0; mGap = 0; mH = 0;
    endtask

    task automatic modelTimeout();
        mStreak = 0; mLocked = 0; mSeen = 0; mHavePrev = 0;
    endtask

    // Applies the measurement rules to one rising edge of fs_in.
    task automatic modelRise();
        int d;
        mFrames++;
        if (mSeen) begin
            if (mHavePrev) begin
                d = (mGap > mPrev) ? mGap - mPrev : mPrev - mGap;
                if (d <= LOCK_TOL) begin
                    if (mStreak < LOCK_FRAMES) mStreak++;
                    if (mStreak >= LOCK_FRAMES) mLocked = 1;
                end else begin
                    mStreak = 0;
                    mLocked = 0;
                end
            end
            mHavePrev = 1;
            mPrev     = mGap;
            expQ.push_back('{32'(mGap), 32'(mH), 32'(mFrames), mLocked});
        end
        mSeen = 1;
    endtask

    task automatic drivePulse(input int n, input int h);
        modelRise();
        for (int i = 0; i < n; i++) begin
            fs_in = (i < h);
            step();
        end
        mGap = n;
        mH   = h;
    endtask

    task automatic startFresh();
        fs_in = 1'b0;
        repeat (6) step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        capQ.delete();
        expQ.delete();
        modelClear();
    endtask

    task automatic test_reset();
        ARESETN = 1'b0; enable = 1'b0; clear = 1'b0; fs_in = 1'b0; timeout_cycles = '0;
        fs8 = 1'b0; en8 = 1'b0; clr8 = 1'b0; to8 = '0;
        repeat (3) step();
        checks++;
        if (period !== 0 || high_width !== 0) begin
            errors++;
            $display("[TB] FAIL reset_measure: got period=%0d hw=%0d expected 0 0", period, high_width);
        end
        checks++;
        if (frame_cnt !== 0) begin
            errors++;
            $display("[TB] FAIL reset_frame: got %0d expected 0", frame_cnt);
        end
        checks++;
        if ({period_valid, locked, timeout} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset_flags: got %b expected 000", {period_valid, locked, timeout});
        end
        ARESETN = 1'b1;
        step();
    endtask

    task automatic test_period_width();
        enable = 1'b1; timeout_cycles = '0;
        startFresh();
        repeat (4) drivePulse(100, 10);
        for (int k = 0; k < 8; k++) begin
            int n;
            n = int'($urandom_range(20, 300));
            drivePulse(n, int'($urandom_range(1, n - 2)));
        end
        checks++;
        if (capQ.size() == 0 || capQ[0].period !== 100 || capQ[0].hw !== 10 || capQ[0].frame !== 2) begin
            errors++;
            $display("[TB] FAIL first_valid: got %0d records (first p/hw/f) expected p=100 hw=10 f=2", capQ.size());
        end
        checks++;
        if (capQ.size() != expQ.size()) begin
            errors++;
            $display("[TB] FAIL basic_count: got %0d records expected %0d", capQ.size(), expQ.size());
        end
        foreach (expQ[i]) begin
            if (i < capQ.size()) begin
                checks++;
                if (capQ[i].period !== expQ[i].period || capQ[i].hw !== expQ[i].hw ||
                    capQ[i].frame !== expQ[i].frame || capQ[i].locked !== expQ[i].locked) begin
                    errors++;
                    $display("[TB] FAIL basic_rec%0d: got p=%0d hw=%0d f=%0d l=%0d expected p=%0d hw=%0d f=%0d l=%0d",
                             i, capQ[i].period, capQ[i].hw, capQ[i].frame, capQ[i].locked,
                             expQ[i].period, expQ[i].hw, expQ[i].frame, expQ[i].locked);
                end
            end
        end
    endtask

    task automatic test_lock();
        int fixedP[6] = '{100, 101, 99, 100, 150, 100};
        int base;
        startFresh();
        foreach (fixedP[i]) drivePulse(fixedP[i], 10);
        checks++;
        if (capQ.size() < 5 || capQ[2].locked !== 1'b0 || capQ[3].locked !== 1'b1) begin
            errors++;
            $display("[TB] FAIL lock_assert: got %0d records expected locked 0 then 1 at record 3", capQ.size());
        end
        checks++;
        if (capQ.size() < 5 || capQ[4].period !== 150 || capQ[4].locked !== 1'b0) begin
            errors++;
            $display("[TB] FAIL lock_drop: got %0d records expected p=150 with locked=0", capQ.size());
        end
        base = int'($urandom_range(60, 120));
        for (int k = 0; k < 12; k++) drivePulse(base + int'($urandom_range(0, 5)), 6);
        checks++;
        if (capQ.size() != expQ.size()) begin
            errors++;
            $display("[TB] FAIL lock_count: got %0d records expected %0d", capQ.size(), expQ.size());
        end
        foreach (expQ[i]) begin
            if (i < capQ.size()) begin
                checks++;
                if (capQ[i].period !== expQ[i].period || capQ[i].locked !== expQ[i].locked ||
                    capQ[i].frame !== expQ[i].frame) begin
                    errors++;
                    $display("[TB] FAIL lock_rec%0d: got p=%0d f=%0d l=%0d expected p=%0d f=%0d l=%0d",
                             i, capQ[i].period, capQ[i].frame, capQ[i].locked,
                             expQ[i].period, expQ[i].frame, expQ[i].locked);
                end
            end
        end
    endtask

    task automatic test_timeout();
        logic [31:0] pBefore;
        startFresh();
        timeout_cycles = 32'd500;
        repeat (5) drivePulse(100, 10);
        for (int i = 0; i < 1500 && timeout !== 1'b1; i++) step();
        checks++;
        if (timeout !== 1'b1) begin
            errors++;
            $display("[TB] FAIL timeout_fire: got %b expected 1 within bound", timeout);
        end
        checks++;
        if (toRiseCyc - lastFrameCyc != 500) begin
            errors++;
            $display("[TB] FAIL timeout_delay: got %0d cycles expected 500", toRiseCyc - lastFrameCyc);
        end
        checks++;
        if (locked !== 1'b0 || capQ.size() != 4 || (capQ.size() == 4 && capQ[3].locked !== 1'b1)) begin
            errors++;
            $display("[TB] FAIL timeout_lock: got locked=%b records=%0d expected 0 and 4 (last locked)", locked, capQ.size());
        end
        modelTimeout();
        pBefore = period;
        drivePulse(80, 10);
        checks++;
        if (period !== pBefore || frame_cnt !== 6 || timeout !== 1'b1 || capQ.size() != 4) begin
            errors++;
            $display("[TB] FAIL timeout_stale: got p=%0d f=%0d to=%b recs=%0d expected p=%0d f=6 to=1 recs=4",
                     period, frame_cnt, timeout, capQ.size(), pBefore);
        end
        drivePulse(90, 12);
        checks++;
        if (capQ.size() != 5 || expQ.size() != 5 ||
            (capQ.size() == 5 && (capQ[4].period !== expQ[4].period || capQ[4].hw !== expQ[4].hw ||
                                  capQ[4].frame !== expQ[4].frame || capQ[4].locked !== expQ[4].locked))) begin
            errors++;
            $display("[TB] FAIL timeout_recover: got %0d records expected 5 with p=80 hw=10 f=7", capQ.size());
        end
        timeout_cycles = '0;
    endtask

    task automatic test_clear_edge();
        startFresh();
        repeat (5) drivePulse(60, 8);
        checks++;
        if (frame_cnt !== 5 || locked !== 1'b1) begin
            errors++;
            $display("[TB] FAIL clear_pre: got f=%0d l=%b expected f=5 l=1", frame_cnt, locked);
        end
        capQ.delete();
        fs_in = 1'b1;
        step();
        step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        checks++;
        if ({period, high_width, frame_cnt} !== 96'd0 || {locked, timeout, period_valid} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL clear_zero: got p=%0d hw=%0d f=%0d flags=%b expected all 0",
                     period, high_width, frame_cnt, {locked, timeout, period_valid});
        end
        repeat (5) step();
        fs_in = 1'b0;
        repeat (40) step();
        checks++;
        if (frame_cnt !== 0 || high_width !== 0 || capQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL clear_dropped: got f=%0d hw=%0d recs=%0d expected 0 0 0", frame_cnt, high_width, capQ.size());
        end
        expQ.delete();
        modelClear();
        drivePulse(70, 9);
        drivePulse(70, 9);
        checks++;
        if (capQ.size() != 1 || capQ[0].period !== 70 || capQ[0].hw !== 9 || capQ[0].frame !== 2) begin
            errors++;
            $display("[TB] FAIL clear_restart: got %0d records expected 1 with p=70 hw=9 f=2", capQ.size());
        end
    endtask

    task automatic test_reset_mid();
        startFresh();
        repeat (2) drivePulse(50, 5);
        fs_in = 1'b1;
        repeat (3 + int'($urandom_range(0, 20))) step();
        ARESETN = 1'b0;
        fs_in = 1'b0;
        #2;
        checks++;
        if ({period, high_width, frame_cnt} !== 96'd0 || {period_valid, locked, timeout} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset_async: got p=%0d hw=%0d f=%0d expected all 0", period, high_width, frame_cnt);
        end
        repeat (3) step();
        ARESETN = 1'b1;
        step();
        checks++;
        if ({period, high_width, frame_cnt} !== 96'd0) begin
            errors++;
            $display("[TB] FAIL reset_release: got p=%0d hw=%0d f=%0d expected all 0", period, high_width, frame_cnt);
        end
        capQ.delete();
        expQ.delete();
        modelClear();
        drivePulse(50, 5);
        checks++;
        if (capQ.size() != 0 || frame_cnt !== 1) begin
            errors++;
            $display("[TB] FAIL reset_first_edge: got recs=%0d f=%0d expected 0 and 1", capQ.size(), frame_cnt);
        end
        drivePulse(50, 5);
        checks++;
        if (capQ.size() != 1 || capQ[0].period !== 50 || capQ[0].frame !== 2) begin
            errors++;
            $display("[TB] FAIL reset_second_edge: got %0d records expected 1 with p=50 f=2", capQ.size());
        end
    endtask

    task automatic test_saturation();
        int          gaps[3];
        int          highs[3];
        int          n8 = 0;
        logic [7:0]  gotP[2];
        logic [7:0]  gotH[2];
        logic [7:0]  gotF[2];
        gaps  = '{int'($urandom_range(300, 500)), int'($urandom_range(20, 200)), 30};
        highs = '{5, 7, 3};
        en8 = 1'b1;
        repeat (4) step();
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < gaps[p]; i++) begin
                fs8 = (i < highs[p]);
                step();
                if (pv8 === 1'b1) begin
                    if (n8 < 2) begin
                        gotP[n8] = period8;
                        gotH[n8] = hw8;
                        gotF[n8] = frame8;
                    end
                    n8++;
                end
            end
        end
        checks++;
        if (n8 != 2) begin
            errors++;
            $display("[TB] FAIL sat_count: got %0d valid pulses expected 2", n8);
        end
        if (n8 >= 2) begin
            checks++;
            if (gotP[0] !== 8'd255 || gotH[0] !== 8'd5 || gotF[0] !== 8'd2) begin
                errors++;
                $display("[TB] FAIL sat_period: got p=%0d hw=%0d f=%0d expected p=255 hw=5 f=2", gotP[0], gotH[0], gotF[0]);
            end
            checks++;
            if (gotP[1] !== 8'(gaps[1]) || gotH[1] !== 8'd7 || gotF[1] !== 8'd3) begin
                errors++;
                $display("[TB] FAIL sat_after: got p=%0d hw=%0d f=%0d expected p=%0d hw=7 f=3", gotP[1], gotH[1], gotF[1], gaps[1]);
            end
        end
        checks++;
        if (lk8 !== 1'b0 || tmo8 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL sat_flags: got l=%b to=%b expected 0 0", lk8, tmo8);
        end
        en8 = 1'b0;
    endtask

    initial begin
        #10_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_period_width();
        test_lock();
        test_timeout();
        test_clear_edge();
        test_reset_mid();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
